interrupt_arbiter: RTL and testbench
====================================

# interrupt_arbiter

Shares the single-context OpenCAPI interrupt engine (`interrupt_tlx`) between NREQ independent interrupt requesters, such as actions or kernels, each with its own source object and context. It sits between the requesters and the engine's AXI-side `interrupt`/`interrupt_ack` handshake. It picks requesters round-robin, presents one request at a time with stable payload, and completes the engine's four-phase handshake before returning an acknowledge to the winner. A watchdog flags engine responses that take too long.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `CTXW`, 9: context width; must match the engine's `interrupt_ctx` width.
- `TOW`, 16: watchdog counter width.

- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `arb_enable` in 1: when 0, no new grants are made; an in-flight request still completes.
- `timeout_limit` in TOW: watchdog threshold in cycles; 0 disables the watchdog.
- `timeout_clr` in 1: one-cycle pulse that clears `timeout_err`.
- `req_valid` in NREQ: per-requester level request.
- `req_src` in NREQ*64: per-requester source object; slice i is bits [64i+63:64i].
- `req_ctx` in NREQ*CTXW: per-requester context.
- `req_ack` out NREQ: one-hot, one-cycle completion pulse.
- `int_req` out 1: goes to the engine's `interrupt` input.
- `int_src` out 64: goes to the engine's `interrupt_src` input.
- `int_ctx` out CTXW: goes to the engine's `interrupt_ctx` input.
- `int_ack` in 1: comes from the engine's `interrupt_ack` output.
- `busy` out 1: 1 whenever the FSM is not in IDLE.
- `grant_id` out clog2(NREQ): index of the current or last winner.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- **Requester rule:** once `req_valid[i]` is raised, it and its `req_src`/`req_ctx` slices are held stable until `req_ack[i]`. The requester drops `req_valid[i]` in the cycle after `req_ack[i]`, or later.
- **IDLE:**
  - If `arb_enable` is 1 and any `req_valid` bit is set, pick the winner g.
  - Register `grant_id`=g, `int_src`=`req_src`[g], `int_ctx`=`req_ctx`[g] and `int_req`=1, then go to ISSUE.
  - Otherwise stay in IDLE.
- **Round-robin pick:** search from pointer `ptr` upward, modulo NREQ, for the first valid bit. At grant, `ptr` <= (g+1) mod NREQ.
- **ISSUE:**
  - `int_req`, `int_src` and `int_ctx` are held constant.
  - On `int_ack`=1: `int_req` <= 0, `req_ack[g]` <= 1 for one cycle, go to RELEASE.
  - Otherwise stay in ISSUE.
  - ISSUE is never abandoned, because the engine cannot abort an issued command.
- **Watchdog:**
  - Counter `to_cnt` is cleared on entry to ISSUE and increments each ISSUE cycle, saturating at all-ones.
  - When `timeout_limit`!=0 and `to_cnt`==`timeout_limit`, set `timeout_err`.
  - `timeout_err` stays set until `timeout_clr` or `rst`. If set and clear coincide, set wins.
- **RELEASE:**
  - `int_req`=0.
  - On `int_ack`=0 (engine back in its IDLE), go to IDLE.
  - Otherwise stay in RELEASE.
- **Masking:** `req_valid[g]` is still high in the first RELEASE cycle, so g is not eligible again until IDLE is reached. The rule that the requester drops valid the cycle after `req_ack` guarantees no double grant.
- **Requesters with no request:** a requester whose `req_valid` is low at pick time is skipped. It receives no state.

## Timing
- **Reset values:** state=IDLE, `ptr`=0, `int_req`=0, `int_src`=0, `int_ctx`=0, `req_ack`=0, `busy`=0, `grant_id`=0, `timeout_err`=0, `to_cnt`=0.
- **Grant latency:** if `req_valid` is seen in IDLE at cycle t, then `int_req`=1 and the payload are valid at t+1.
- **Acknowledge latency:** if `int_ack` rises at cycle t, then `req_ack[g]`=1 and `int_req`=0 at t+1. `req_ack` is exactly one cycle wide.
- **Back-to-back requests:** after `int_ack` falls at cycle t, the FSM is in IDLE at t+1 and the next `int_req` asserts at t+2. The minimum period per interrupt is 4 cycles plus engine latency.
- **Reset mid-operation:** `rst` in any state forces the reset values on the next edge; any in-flight requester receives no `req_ack`. The system resets the engine together with the arbiter.
- **`arb_enable` drop:** a drop during ISSUE or RELEASE has no effect until IDLE.

## Structure
- Shared package `interrupt_arbiter_pkg`:
  - state encodings IDLE=3'b001, ISSUE=3'b010, RELEASE=3'b100 (one-hot);
  - the default NREQ;
  - a `clog2` function.
- Sub-module `interrupt_rr_pick` holds the combinational round-robin search from `ptr` over `req_valid`. Its outputs are `pick_vld` and `pick_id`, for NREQ up to 16.
- The top level holds the FSM, payload registers, `ptr`, the watchdog and the status outputs.

## Test plan
- **Single request:** `req_valid[2]` with src=0xDEAD_BEEF_0000_0010, ctx=5. Expect `int_req` high one cycle later with the same payload. The engine model acks after 10 cycles, which yields a single `req_ack[2]` pulse. The engine drops its ack, then `busy` returns to 0.
- **Fairness under contention:**
  - `req_valid` 4'b1111 held, with each requester re-raising after its ack. Expect grant order 0,1,2,3,0.
  - Then `ptr`=1 with only bits 3 and 0 set. Expect grant 3, then 0.
- **Payload stability:** change unrelated requesters' src during ISSUE. `int_src`/`int_ctx` stay constant from grant until the cycle after `int_ack`.
- **Watchdog:**
  - `timeout_limit`=20 with the engine acking at 25. `timeout_err` sets at ISSUE cycle 20. The ack still completes normally.
  - `timeout_clr` clears the flag.
  - With `timeout_limit`=0 and a 100-cycle ack, the flag is never set.
- **Enable gating:** `arb_enable`=0 with `req_valid`=4'b0011 gives no `int_req`. Raising `arb_enable` grants requester 0 one cycle later.
- **Reset mid-flight:** assert `rst` in ISSUE and in RELEASE. All outputs return to their reset values on the next cycle, and no `req_ack` is produced.

Source files
------------

// File: rtl/interrupt_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_arbiter_pkg
// Description : Shared definitions for the interrupt arbiter: one-hot FSM
//               state encodings, the default requester count and a
//               constant-evaluable ceil(log2) helper used for index widths.
// Revision    : 1.0 - initial release
// ============================================================================
package interrupt_arbiter_pkg;

    // Default number of requesters sharing the engine.
    localparam int c_NREQ_DEFAULT = 4;

    // One-hot FSM state encodings.
    localparam logic [2:0] c_ST_IDLE    = 3'b001;
    localparam logic [2:0] c_ST_ISSUE   = 3'b010;
    localparam logic [2:0] c_ST_RELEASE = 3'b100;

    // ceil(log2(value)); bounded loop so it stays a constant function.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_rr_pick
// Description : Combinational round-robin search. Starting at ptr and
//               wrapping modulo NREQ, returns the first set bit of req_valid.
// Ports       : req_valid [NREQ]        - per-requester request levels
//               ptr       [clog2(NREQ)] - search start position (< NREQ)
//               pick_vld                - at least one request is set
//               pick_id   [clog2(NREQ)] - index of the selected requester
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_rr_pick
    import interrupt_arbiter_pkg::*;
#(
    parameter int NREQ = c_NREQ_DEFAULT
) (
    input  logic [NREQ-1:0]        req_valid,
    input  logic [clog2(NREQ)-1:0] ptr,
    output logic                   pick_vld,
    output logic [clog2(NREQ)-1:0] pick_id
);

    localparam int c_IDW = clog2(NREQ);

    // Scan offsets from farthest to nearest so the candidate closest to ptr
    // is the last one written and therefore wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (req_valid[idx]) begin
                pick_vld = 1'b1;
                pick_id  = c_IDW'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_arbiter
// Description : Shares a single-context interrupt engine between NREQ
//               requesters. Round-robin grant, stable payload while the
//               engine's four-phase interrupt/interrupt_ack handshake runs,
//               one-cycle req_ack to the winner, and a sticky watchdog flag
//               for slow engine responses.
// Ports       : clk, rst                 - clock, sync active-high reset
//               arb_enable               - permits new grants
//               timeout_limit/_clr       - watchdog threshold / flag clear
//               req_valid/_src/_ctx      - requester side (packed slices)
//               req_ack                  - one-hot completion pulse
//               int_req/_src/_ctx        - to engine
//               int_ack                  - from engine
//               busy, grant_id, timeout_err - status
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter int NREQ = c_NREQ_DEFAULT,
    parameter int CTXW = 9,
    parameter int TOW  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arb_enable,
    input  logic [TOW-1:0]         timeout_limit,
    input  logic                   timeout_clr,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*64-1:0]     req_src,
    input  logic [NREQ*CTXW-1:0]   req_ctx,
    output logic [NREQ-1:0]        req_ack,
    output logic                   int_req,
    output logic [63:0]            int_src,
    output logic [CTXW-1:0]        int_ctx,
    input  logic                   int_ack,
    output logic                   busy,
    output logic [clog2(NREQ)-1:0] grant_id,
    output logic                   timeout_err
);

    localparam int c_IDW = clog2(NREQ);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [c_IDW-1:0] r_ptr;
    logic             r_int_req;
    logic [63:0]      r_int_src;
    logic [CTXW-1:0]  r_int_ctx;
    logic [NREQ-1:0]  r_req_ack;
    logic [c_IDW-1:0] r_grant_id;
    logic [TOW-1:0]   r_to_cnt;
    logic [TOW-1:0]   w_to_next;
    logic             w_to_hit;
    logic             r_timeout_err;
    logic             w_grant;
    logic             w_ack_fire;
    logic             w_pick_vld;
    logic [c_IDW-1:0] w_pick_id;

    logic [63:0]      w_src_arr [NREQ];
    logic [CTXW-1:0]  w_ctx_arr [NREQ];

    // Unpack the flat requester buses so the winner can be muxed by index.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_src_arr[i] = req_src[64*i +: 64];
        assign w_ctx_arr[i] = req_ctx[CTXW*i +: CTXW];
    end

    interrupt_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (r_ptr),
        .pick_vld  (w_pick_vld),
        .pick_id   (w_pick_id)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and event strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_ack_fire   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (arb_enable && w_pick_vld) begin
                    w_grant      = 1'b1;
                    w_next_state = c_ST_ISSUE;
                end
            end
            // The engine cannot abort an issued command, so ISSUE only
            // exits on the acknowledge.
            c_ST_ISSUE: begin
                if (int_ack) begin
                    w_ack_fire   = 1'b1;
                    w_next_state = c_ST_RELEASE;
                end
            end
            // Wait for the engine to return to idle before re-arbitrating.
            c_ST_RELEASE: begin
                if (!int_ack) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Watchdog: saturating count of ISSUE cycles. The flag is raised on the
    // same edge that moves the count onto the threshold.
    assign w_to_next = (&r_to_cnt) ? r_to_cnt : r_to_cnt + TOW'(1);
    assign w_to_hit  = (r_state == c_ST_ISSUE) && (timeout_limit != '0) &&
                       (w_to_next == timeout_limit);

    // ------------------------------------------------------------------
    // Datapath: pointer, payload, acknowledge, watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr         <= '0;
            r_int_req     <= 1'b0;
            r_int_src     <= '0;
            r_int_ctx     <= '0;
            r_req_ack     <= '0;
            r_grant_id    <= '0;
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_req_ack <= '0;

            if (w_grant) begin
                r_grant_id <= w_pick_id;
                r_int_src  <= w_src_arr[w_pick_id];
                r_int_ctx  <= w_ctx_arr[w_pick_id];
                r_int_req  <= 1'b1;
                r_ptr      <= (w_pick_id == c_IDW'(NREQ - 1)) ? '0
                                                              : w_pick_id + c_IDW'(1);
            end

            if (w_ack_fire) begin
                r_int_req             <= 1'b0;
                r_req_ack[r_grant_id] <= 1'b1;
            end

            if (w_grant) begin
                r_to_cnt <= '0;
            end else if (r_state == c_ST_ISSUE) begin
                r_to_cnt <= w_to_next;
            end

            // A set coinciding with a clear takes priority.
            if (w_to_hit) begin
                r_timeout_err <= 1'b1;
            end else if (timeout_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign req_ack     = r_req_ack;
    assign int_req     = r_int_req;
    assign int_src     = r_int_src;
    assign int_ctx     = r_int_ctx;
    assign busy        = (r_state != c_ST_IDLE);
    assign grant_id    = r_grant_id;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_arbiter
// Description : Directed self-checking bench for interrupt_arbiter. Expected
//               grants (id and payload) are queued when a requester raises
//               its request and popped when the arbiter issues to the
//               engine model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_arbiter;

    localparam int NREQ = 4;
    localparam int CTXW = 9;
    localparam int TOW  = 16;

    typedef struct {
        int              id;
        logic [63:0]     src;
        logic [CTXW-1:0] ctx;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic                 arb_enable;
    logic [TOW-1:0]       timeout_limit;
    logic                 timeout_clr;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*64-1:0]   req_src;
    logic [NREQ*CTXW-1:0] req_ctx;
    logic [NREQ-1:0]      req_ack;
    logic                 int_req;
    logic [63:0]          int_src;
    logic [CTXW-1:0]      int_ctx;
    logic                 int_ack;
    logic                 busy;
    logic [1:0]           grant_id;
    logic                 timeout_err;

    int   n_checks;
    int   n_err;
    exp_t sb [$];

    interrupt_arbiter #(
        .NREQ (NREQ),
        .CTXW (CTXW),
        .TOW  (TOW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arb_enable    (arb_enable),
        .timeout_limit (timeout_limit),
        .timeout_clr   (timeout_clr),
        .req_valid     (req_valid),
        .req_src       (req_src),
        .req_ctx       (req_ctx),
        .req_ack       (req_ack),
        .int_req       (int_req),
        .int_src       (int_src),
        .int_ctx       (int_ctx),
        .int_ack       (int_ack),
        .busy          (busy),
        .grant_id      (grant_id),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=stalled expected=finish");
        $fatal(1, "bench time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_int_req"},  {63'd0, int_req},     64'd0);
        check({tag, "_int_src"},  int_src,              64'd0);
        check({tag, "_int_ctx"},  {55'd0, int_ctx},     64'd0);
        check({tag, "_req_ack"},  {60'd0, req_ack},     64'd0);
        check({tag, "_busy"},     {63'd0, busy},        64'd0);
        check({tag, "_grant_id"}, {62'd0, grant_id},    64'd0);
        check({tag, "_tmo_err"},  {63'd0, timeout_err}, 64'd0);
    endtask

    task automatic drive_req(input int id, input logic [63:0] src, input logic [CTXW-1:0] ctx);
        req_src[64*id +: 64]     = src;
        req_ctx[CTXW*id +: CTXW] = ctx;
        req_valid[id]            = 1'b1;
    endtask

    task automatic raise(input int id, input logic [63:0] src, input logic [CTXW-1:0] ctx);
        exp_t e;
        drive_req(id, src, ctx);
        e.id  = id;
        e.src = src;
        e.ctx = ctx;
        sb.push_back(e);
    endtask

    task automatic raise_rand(input int id);
        raise(id, {32'hA000_0000 | 32'(id), $urandom}, CTXW'($urandom_range(0, 511)));
    endtask

    task automatic wait_int_req(output bit ok);
        int n;
        n = 0;
        while (int_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (int_req === 1'b1);
        if (!ok) begin
            n_checks++;
            n_err++;
            $error("FAIL grant_timeout observed int_req=%b expected=1", int_req);
        end
    endtask

    // Engine model plus scoreboard pop: waits for the issue, checks payload
    // and stability every cycle, acks after 'delay' cycles, checks the
    // one-cycle req_ack, then the winner drops its request.
    task automatic serve(input int delay, input bit reraise, input int err_from);
        exp_t e;
        bit   ok;
        int   g;
        wait_int_req(ok);
        if (!ok) return;
        if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL scoreboard_empty observed=grant expected=none");
            return;
        end
        e = sb.pop_front();
        g = e.id;
        check("grant_id", {62'd0, grant_id}, 64'(g));
        check("int_src",  int_src, e.src);
        check("int_ctx",  {55'd0, int_ctx}, 64'(e.ctx));
        check("busy_issue", {63'd0, busy}, 64'd1);
        for (int i = 1; i <= delay; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (j != g && req_valid[j] == 1'b0) req_src[64*j +: 64] = {$urandom, $urandom};
            end
            @(negedge clk);
            check("hold_src", int_src, e.src);
            check("hold_req", {63'd0, int_req}, 64'd1);
            check("wdog", {63'd0, timeout_err}, {63'd0, (err_from >= 0 && i >= err_from)});
        end
        int_ack = 1'b1;
        @(negedge clk);
        check("req_ack",     {60'd0, req_ack}, 64'(1 << g));
        check("req_dropped", {63'd0, int_req}, 64'd0);
        check("src_post_ack", int_src, e.src);
        int_ack = 1'b0;
        @(negedge clk);
        check("ack_width", {60'd0, req_ack}, 64'd0);
        check("busy_idle", {63'd0, busy}, 64'd0);
        req_valid[g] = 1'b0;
        @(negedge clk);
        if (reraise) raise_rand(g);
    endtask

    initial begin
        bit ok;
        n_checks      = 0;
        n_err         = 0;
        rst           = 1'b1;
        arb_enable    = 1'b1;
        timeout_limit = '0;
        timeout_clr   = 1'b0;
        req_valid     = '0;
        req_src       = '0;
        req_ctx       = '0;
        int_ack       = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        @(negedge clk);

        // Single request with one-cycle grant latency.
        raise(2, 64'hDEAD_BEEF_0000_0010, 9'd5);
        @(negedge clk);
        check("grant_latency", {63'd0, int_req}, 64'd1);
        serve(10, 1'b0, -1);

        // Fairness: fresh pointer, all four requesting.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) raise_rand(i);
        serve(3, 1'b1, -1);   // 0
        serve(4, 1'b0, -1);   // 1
        serve(2, 1'b0, -1);   // 2
        serve(5, 1'b1, -1);   // 3
        serve(3, 1'b1, -1);   // 0, pointer now 1, bits 3 and 0 set
        serve(2, 1'b0, -1);   // 3
        serve(2, 1'b0, -1);   // 0

        // Watchdog at 20 with the engine answering at 25.
        timeout_limit = 16'd20;
        raise_rand(1);
        serve(25, 1'b0, 20);
        check("wdog_sticky", {63'd0, timeout_err}, 64'd1);
        timeout_clr = 1'b1;
        @(negedge clk);
        timeout_clr = 1'b0;
        check("wdog_clr", {63'd0, timeout_err}, 64'd0);

        // Watchdog disabled with a long engine response.
        timeout_limit = '0;
        raise_rand(2);
        serve(100, 1'b0, -1);

        // Enable gating.
        arb_enable = 1'b0;
        raise_rand(0);
        raise_rand(1);
        repeat (5) begin
            @(negedge clk);
            check("gated_req",  {63'd0, int_req}, 64'd0);
            check("gated_busy", {63'd0, busy}, 64'd0);
        end
        arb_enable = 1'b1;
        @(negedge clk);
        check("enable_grant", {63'd0, int_req}, 64'd1);
        serve(6, 1'b0, -1);
        serve(6, 1'b0, -1);

        // Reset while in ISSUE.
        drive_req(3, 64'h0123_4567_89AB_CDEF, 9'h1A5);
        wait_int_req(ok);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_issue");
        rst          = 1'b0;
        req_valid[3] = 1'b0;
        @(negedge clk);
        check("rst_issue_noack", {60'd0, req_ack}, 64'd0);
        check("rst_issue_idle",  {63'd0, int_req}, 64'd0);

        // Reset while in RELEASE (engine still holding its ack).
        drive_req(3, 64'hFEDC_BA98_7654_3210, 9'h0F0);
        wait_int_req(ok);
        int_ack = 1'b1;
        @(negedge clk);
        check("rel_req_ack", {60'd0, req_ack}, 64'd8);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_release");
        rst          = 1'b0;
        req_valid[3] = 1'b0;
        int_ack      = 1'b0;
        @(negedge clk);
        check("rst_rel_noack", {60'd0, req_ack}, 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
